// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit for the pipelined CPU.
// Each architectural register owns a countdown timer giving the number of
// cycles until its in-flight result can be forwarded to the EX input. The ID
// stage compares those timers against what each instruction needs and drives
// the IF/ID stall, the EX bubble and the IF squash from the result.
module scoreboard_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic [1:0]             id_pc_src,
    input  logic                   branch_taken,
    input  logic                   id_reg_write,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic [LAT_W-1:0]       id_lat,
    input  logic                   id_is_mdu,
    input  logic                   mdu_busy,
    input  logic                   pipe_flush,
    output logic                   stall_if_id,
    output logic                   bubble_ex,
    output logic                   flush_if,
    output logic [(2**REG_AW)-1:0] sb_pending,
    output logic [CNT_W-1:0]       stall_count
);

    localparam int               NUM_REGS  = 2 ** REG_AW;
    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [1:0]       PC_BRANCH = 2'b01;
    localparam logic [1:0]       PC_JUMP   = 2'b10;
    localparam logic [1:0]       PC_JR     = 2'b11;

    logic [LAT_W-1:0] timer [NUM_REGS];
    logic [LAT_W-1:0] rsTimer;
    logic [LAT_W-1:0] rtTimer;
    logic [LAT_W-1:0] rdTimer;
    logic [LAT_W-1:0] issueLat;
    logic             rsNeedsZero;
    logic             rtNeedsZero;
    logic             rsReady;
    logic             rtReady;
    logic             srcHazard;
    logic             wawHazard;
    logic             mduHazard;
    logic             stall;
    logic             redirect;
    logic             issue;
    logic             trackWrite;

    assign rsTimer = timer[id_rs];
    assign rtTimer = timer[id_rt];
    assign rdTimer = timer[id_rd];

    // Hazard detection: operands resolved in ID (branch compare, jr target) need the value already written back, everyone else can take a forward
    always_comb begin
        rsNeedsZero = (id_pc_src == PC_BRANCH) || (id_pc_src == PC_JR);
        rtNeedsZero = (id_pc_src == PC_BRANCH);
        rsReady     = rsNeedsZero ? (rsTimer == '0) : (rsTimer <= LAT_ONE);
        rtReady     = rtNeedsZero ? (rtTimer == '0) : (rtTimer <= LAT_ONE);
        srcHazard   = (id_use_rs && !rsReady) || (id_use_rt && !rtReady);
        wawHazard   = id_reg_write && (id_rd != '0) && (rdTimer > id_lat);
        mduHazard   = id_is_mdu && mdu_busy;
        stall       = id_valid && !pipe_flush && (srcHazard || wawHazard || mduHazard);
        redirect    = (id_pc_src == PC_JUMP) || (id_pc_src == PC_JR) ||
                      ((id_pc_src == PC_BRANCH) && branch_taken);
        issue       = id_valid && !stall && !pipe_flush;
        trackWrite  = issue && id_reg_write && (id_rd != '0) && (id_lat != '0);
        issueLat    = (id_lat > MAX_LAT_V) ? MAX_LAT_V : id_lat;
    end

    assign stall_if_id = stall;
    assign bubble_ex   = stall;
    assign flush_if    = id_valid && !pipe_flush && !stall && redirect;

    // Timers load on issue of a tracked writer, otherwise count down to zero; a pipeline flush kills every in-flight writer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                timer[r] <= '0;
            end
        end else if (pipe_flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                timer[r] <= '0;
            end
        end else begin
            timer[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (trackWrite && (id_rd == REG_AW'(r))) begin
                    timer[r] <= issueLat;
                end else if (timer[r] != '0) begin
                    timer[r] <= timer[r] - LAT_ONE;
                end
            end
        end
    end

    // Expose which registers still have a result in flight
    always_comb begin
        sb_pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_pending[r] = (timer[r] != '0);
        end
    end

    // Count stalled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit.
// Each scenario builds a list of per-cycle stimulus with hand-derived
// expectations; driving a cycle pushes its expectation onto a scoreboard
// queue, which is popped and compared once the outputs have settled.
// The counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_scoreboard_hazard_unit;

    localparam logic [31:0] B8  = 32'h0000_0100;
    localparam logic [31:0] B9  = 32'h0000_0200;
    localparam logic [31:0] B10 = 32'h0000_0400;
    localparam logic [31:0] B11 = 32'h0000_0800;
    localparam logic [31:0] B12 = 32'h0000_1000;
    localparam logic [31:0] B14 = 32'h0000_4000;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic        useRs;
        logic [4:0]  rt;
        logic        useRt;
        logic [1:0]  pcSrc;
        logic        taken;
        logic        regWrite;
        logic [4:0]  rd;
        logic [3:0]  lat;
        logic        isMdu;
        logic        mduBusy;
        logic        flush;
        logic        expStall;
        logic        expFlush;
        logic [31:0] expPend;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] pend;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [1:0]  id_pc_src;
    logic        branch_taken;
    logic        id_reg_write;
    logic [4:0]  id_rd;
    logic [3:0]  id_lat;
    logic        id_is_mdu;
    logic        mdu_busy;
    logic        pipe_flush;
    logic        stall_if_id;
    logic        bubble_ex;
    logic        flush_if;
    logic [31:0] sb_pending;
    logic [3:0]  stall_count;

    exp_t        expQ[$];
    logic [3:0]  expCount;
    int          nCompared   = 0;
    int          nMismatched = 0;

    scoreboard_hazard_unit #(
        .REG_AW (5),
        .MAX_LAT(8),
        .LAT_W  (4),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_pc_src   (id_pc_src),
        .branch_taken(branch_taken),
        .id_reg_write(id_reg_write),
        .id_rd       (id_rd),
        .id_lat      (id_lat),
        .id_is_mdu   (id_is_mdu),
        .mdu_busy    (mdu_busy),
        .pipe_flush  (pipe_flush),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .flush_if    (flush_if),
        .sb_pending  (sb_pending),
        .stall_count (stall_count)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic uRs,
                                 input logic [4:0] rt, input logic uRt, input logic [1:0] pc,
                                 input logic tk, input logic wr, input logic [4:0] rd,
                                 input logic [3:0] lat, input logic mdu, input logic busy,
                                 input logic fl, input logic eStall, input logic eFlush,
                                 input logic [31:0] ePend);
        stim_t s;
        s.valid = v;  s.rs = rs;  s.useRs = uRs;  s.rt = rt;  s.useRt = uRt;
        s.pcSrc = pc; s.taken = tk; s.regWrite = wr; s.rd = rd; s.lat = lat;
        s.isMdu = mdu; s.mduBusy = busy; s.flush = fl;
        s.expStall = eStall; s.expFlush = eFlush; s.expPend = ePend;
        return s;
    endfunction

    // Empty ID slot
    function automatic stim_t idleS(input logic [31:0] pend);
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 4'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pend);
    endfunction

    // Sequential register-writing instruction (ALU or MDU class)
    function automatic stim_t aluS(input logic [4:0] rs, input logic uRs, input logic [4:0] rt,
                                   input logic uRt, input logic [4:0] rd, input logic [3:0] lat,
                                   input logic mdu, input logic eStall, input logic [31:0] pend);
        return mk(1'b1, rs, uRs, rt, uRt, 2'b00, 1'b0, 1'b1, rd, lat,
                  mdu, 1'b0, 1'b0, eStall, 1'b0, pend);
    endfunction

    // Control-flow instruction with no destination
    function automatic stim_t ctlS(input logic [1:0] pc, input logic [4:0] rs, input logic uRs,
                                   input logic [4:0] rt, input logic uRt, input logic tk,
                                   input logic eStall, input logic eFlush, input logic [31:0] pend);
        return mk(1'b1, rs, uRs, rt, uRt, pc, tk, 1'b0, 5'd0, 4'd0,
                  1'b0, 1'b0, 1'b0, eStall, eFlush, pend);
    endfunction

    // Drive one cycle of inputs and queue what the outputs must show this cycle
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        id_valid     = s.valid;
        id_rs        = s.rs;
        id_use_rs    = s.useRs;
        id_rt        = s.rt;
        id_use_rt    = s.useRt;
        id_pc_src    = s.pcSrc;
        branch_taken = s.taken;
        id_reg_write = s.regWrite;
        id_rd        = s.rd;
        id_lat       = s.lat;
        id_is_mdu    = s.isMdu;
        mdu_busy     = s.mduBusy;
        pipe_flush   = s.flush;
        e.stall = s.expStall;
        e.flush = s.expFlush;
        e.pend  = s.expPend;
        e.cnt   = expCount;
        expQ.push_back(e);
        if (s.expStall && expCount != 4'hF) expCount = expCount + 4'd1;
    endtask

    // Hold reset across two edges with an idle ID stage, release on a falling edge
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(idleS(32'h0));
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        expCount = 4'd0;
    endtask

    // Reset state, then outputs driven purely by inputs (jump flush, MDU busy stall)
    task automatic test_reset();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(idleS(32'h0));
        s.push_back(ctlS(2'b10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
        s.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 4'd0,
                       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL reset step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // Load (lat 2) followed by a dependent add costs exactly one stall cycle
    task automatic test_load_use();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 4'd2, 1'b0, 1'b0, 32'h0));
        s.push_back(aluS(5'd8, 1'b1, 5'd1, 1'b1, 5'd11, 4'd1, 1'b0, 1'b1, B8));
        s.push_back(aluS(5'd8, 1'b1, 5'd1, 1'b1, 5'd11, 4'd1, 1'b0, 1'b0, B8));
        s.push_back(idleS(B11));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL load_use step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // ALU producer then beq (taken and not taken) and jr: one stall, flush only when redirecting
    task automatic test_branch();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 4'd1, 1'b0, 1'b0, 32'h0));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, B8));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0));
        s.push_back(idleS(32'h0));
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 4'd1, 1'b0, 1'b0, 32'h0));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, B8));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 4'd1, 1'b0, 1'b0, 32'h0));
        s.push_back(ctlS(2'b11, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, B9));
        s.push_back(ctlS(2'b11, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL branch step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // MDU to $t1 with latency 6: dependent add stalls 5 cycles, pending bit drops 6 cycles after issue
    task automatic test_mdu();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 4'd6, 1'b1, 1'b0, 32'h0));
        for (int k = 0; k < 5; k++) begin
            s.push_back(aluS(5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 4'd1, 1'b0, 1'b1, B9));
        end
        s.push_back(aluS(5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 4'd1, 1'b0, 1'b0, B9));
        s.push_back(idleS(B12));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL mdu step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // WAW: ALU write behind a slow MDU write to $t2 waits until the timer reaches 1, then reloads it to 1
    task automatic test_waw();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 4'd6, 1'b1, 1'b0, 32'h0));
        for (int k = 0; k < 5; k++) begin
            s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 4'd1, 1'b0, 1'b1, B10));
        end
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 4'd1, 1'b0, 1'b0, B10));
        s.push_back(idleS(B10));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL waw step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // Writes to $zero and latency-0 writes are never tracked
    task automatic test_zero();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd6, 1'b0, 1'b0, 32'h0));
        s.push_back(ctlS(2'b01, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0));
        s.push_back(idleS(32'h0));
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 4'd0, 1'b0, 1'b0, 32'h0));
        s.push_back(ctlS(2'b01, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL zero step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // Latency 15 is clamped to MAX_LAT=8, so the pending bit lasts 8 cycles
    task automatic test_clamp();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 4'd15, 1'b0, 1'b0, 32'h0));
        for (int k = 0; k < 8; k++) s.push_back(idleS(B14));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL clamp step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // pipe_flush with three timers running: no stall/flush that cycle, scoreboard empty next cycle
    task automatic test_flush();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 4'd6, 1'b0, 1'b0, 32'h0));
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 4'd5, 1'b0, 1'b0, B8));
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 4'd4, 1'b0, 1'b0, B8 | B9));
        s.push_back(mk(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd11, 4'd1,
                       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, B8 | B9 | B10));
        s.push_back(idleS(32'h0));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL flush step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // Back-to-back ALU forwarding chain (no bubbles), then load feeding a branch (two bubbles)
    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 4'd1, 1'b0, 1'b0, 32'h0));
        s.push_back(aluS(5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 4'd1, 1'b0, 1'b0, B8));
        s.push_back(aluS(5'd9, 1'b1, 5'd8, 1'b1, 5'd10, 4'd1, 1'b0, 1'b0, B9));
        s.push_back(idleS(B10));
        s.push_back(idleS(32'h0));
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 4'd2, 1'b0, 1'b0, 32'h0));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, B8));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, B8));
        s.push_back(ctlS(2'b01, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0));
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL back_to_back step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // Eighteen MDU-busy stalls: the 4-bit counter must stick at 15
    task automatic test_saturation();
        stim_t s[$];
        exp_t  e;
        doReset();
        for (int k = 0; k < 18; k++) begin
            s.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 4'd0,
                           1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
        end
        s.push_back(idleS(32'h0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL saturation step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    // Reset dropped in the middle of an MDU-induced stall clears everything without waiting for a clock
    task automatic test_async_reset();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(aluS(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 4'd6, 1'b1, 1'b0, 32'h0));
        s.push_back(aluS(5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 4'd1, 1'b0, 1'b1, B9));
        s.push_back(aluS(5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 4'd1, 1'b0, 1'b1, B9));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #1;
            e = expQ.pop_front();
            nCompared++;
            if (stall_if_id !== e.stall || bubble_ex !== e.stall || flush_if !== e.flush ||
                sb_pending !== e.pend || stall_count !== e.cnt) begin
                nMismatched++;
                $display("[TB] FAIL async_reset step %0d: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected stall=%b flush=%b pend=%h cnt=%0d",
                         i, stall_if_id, bubble_ex, flush_if, sb_pending, stall_count, e.stall, e.flush, e.pend, e.cnt);
            end
            @(negedge clk);
        end
        #1;
        nCompared++;
        if (stall_if_id !== 1'b1 || stall_count !== 4'd2 || sb_pending !== B9) begin
            nMismatched++;
            $display("[TB] FAIL async_reset pre: got stall=%b cnt=%0d pend=%h, expected stall=1 cnt=2 pend=%h",
                     stall_if_id, stall_count, sb_pending, B9);
        end
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0 || flush_if !== 1'b0 ||
            sb_pending !== 32'h0 || stall_count !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset clear: got stall=%b bubble=%b flush=%b pend=%h cnt=%0d, expected all zero",
                     stall_if_id, bubble_ex, flush_if, sb_pending, stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(idleS(32'h0));
        expQ.delete();
    endtask

    // Run every scenario in turn, then report
    initial begin
        expCount = 4'd0;
        rst_n    = 1'b0;
        applyStimulus(idleS(32'h0));
        expQ.delete();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_waw();
        test_zero();
        test_clamp();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
